// File: rtl/datapath_if.sv
// Control strobes and observation taps of the single-bus datapath.
// There is no handshake: every strobe is a level sampled on each rising
// Clock, and every observation signal is a continuous view of a register or
// of the bus in the current cycle.
interface datapath_if;
  // Register load enables
  logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  // Bus drive enables
  logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout;
  // Select-and-encode, memory and PC controls
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write;
  logic [31:0] inportInput;
  logic [15:0] regIn;
  // Observation
  logic [31:0] busMuxOut;
  logic [4:0]  encoderOut;
  logic        CON;
  logic [31:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3, BusMuxInR4, BusMuxInR5;
  logic [31:0] BusMuxInR6, BusMuxInR7, BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11;
  logic [31:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15;
  logic [31:0] BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC, BusMuxInMDR;
  logic [31:0] BusMuxInInport, BusMuxInOutport, BusMuxInY;
  logic [31:0] IRregister, Cregister;
  logic [8:0]  marToRam;

  modport master (
    output HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
    output HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout,
    output Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write, inportInput, regIn,
    input  busMuxOut, encoderOut, CON,
    input  BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3, BusMuxInR4, BusMuxInR5,
    input  BusMuxInR6, BusMuxInR7, BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
    input  BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
    input  BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC, BusMuxInMDR,
    input  BusMuxInInport, BusMuxInOutport, BusMuxInY, IRregister, Cregister, marToRam
  );

  modport slave (
    input  HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
    input  HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write, inportInput, regIn,
    output busMuxOut, encoderOut, CON,
    output BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3, BusMuxInR4, BusMuxInR5,
    output BusMuxInR6, BusMuxInR7, BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
    output BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
    output BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC, BusMuxInMDR,
    output BusMuxInInport, BusMuxInOutport, BusMuxInY, IRregister, Cregister, marToRam
  );
endinterface

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, ALU,
// select-and-encode logic, branch flag and an internal word RAM. All moves
// go over one bus whose source is chosen by the external sequencer.
module datapath #(
  parameter string INIT_FILE = "ram.hex",
  parameter int    RAM_DEPTH = 512
) (
  input logic     Clock,
  input logic     Reset,
  datapath_if.slave io
);
  localparam logic [4:0] OP_SUB  = 5'b00100, OP_AND  = 5'b00101, OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111, OP_ROL  = 5'b01000, OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010, OP_SHL  = 5'b01011, OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110, OP_DIV  = 5'b01111, OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001, OP_NOT  = 5'b10010;

  logic [31:0] r [16];
  logic [31:0] hi, lo, pc, ir, y, mdr, inport, outport;
  logic [63:0] z;
  logic [8:0]  mar;
  logic        con;
  logic [31:0] mem [RAM_DEPTH];

  logic [3:0]  sel;
  logic [31:0] c_sx, bus;
  logic [4:0]  enc;
  logic [63:0] alu;
  logic        con_next;

  initial begin
    for (int n = 0; n < RAM_DEPTH; n++) mem[n] = '0;
  end

  assign sel  = ({4{io.Gra}} & ir[26:23]) | ({4{io.Grb}} & ir[22:19]) | ({4{io.Grc}} & ir[18:15]);
  assign c_sx = {{13{ir[18]}}, ir[18:0]};

  // Bus source selection; codes are tested lowest first so the lowest code wins
  always_comb begin
    bus = '0;
    enc = 5'd31;
    if (io.Rout || io.BAout) begin
      bus = (io.BAout && sel == 4'd0) ? 32'd0 : r[sel];
      enc = {1'b0, sel};
    end
    else if (io.HIout)      begin bus = hi;          enc = 5'd16; end
    else if (io.LOout)      begin bus = lo;          enc = 5'd17; end
    else if (io.ZHIout)     begin bus = z[63:32];    enc = 5'd18; end
    else if (io.ZLOout)     begin bus = z[31:0];     enc = 5'd19; end
    else if (io.PCout)      begin bus = pc;          enc = 5'd20; end
    else if (io.MDRout)     begin bus = mdr;         enc = 5'd21; end
    else if (io.INPORTout)  begin bus = inport;      enc = 5'd22; end
    else if (io.Cout)       begin bus = c_sx;        enc = 5'd23; end
    else if (io.Yout)       begin bus = y;           enc = 5'd24; end
    else if (io.OUTPORTout) begin bus = outport;     enc = 5'd25; end
  end

  // ALU: A operand is Y, B operand is the bus; Zhi only carries mul/div results
  always_comb begin
    logic [4:0]         shamt;
    logic signed [63:0] prod;
    logic signed [31:0] sa, sb;
    shamt = bus[4:0];
    sa    = $signed(y);
    sb    = $signed(bus);
    prod  = 64'(sa) * 64'(sb);
    alu   = {32'd0, y + bus};
    case (ir[31:27])
      OP_SUB:          alu = {32'd0, y - bus};
      OP_AND, OP_ANDI: alu = {32'd0, y & bus};
      OP_OR, OP_ORI:   alu = {32'd0, y | bus};
      OP_SHR:          alu = {32'd0, y >> shamt};
      OP_SHRA:         alu = {32'd0, 32'(sa >>> shamt)};
      OP_SHL:          alu = {32'd0, y << shamt};
      OP_ROR:          alu = {32'd0, (y >> shamt) | (y << (6'd32 - {1'b0, shamt}))};
      OP_ROL:          alu = {32'd0, (y << shamt) | (y >> (6'd32 - {1'b0, shamt}))};
      OP_MUL:          alu = prod;
      OP_DIV:          alu = (bus == 32'd0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      OP_NEG:          alu = {32'd0, -bus};
      OP_NOT:          alu = {32'd0, ~bus};
      default:         alu = {32'd0, y + bus};
    endcase
  end

  // Branch condition on the current bus value, chosen by IR c2
  always_comb begin
    case (ir[20:19])
      2'b00:   con_next = (bus == 32'd0);
      2'b01:   con_next = (bus != 32'd0);
      2'b10:   con_next = ~bus[31];
      default: con_next = bus[31];
    endcase
  end

  // Register file and special registers; reset clears everything except RAM
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int n = 0; n < 16; n++) r[n] <= '0;
      hi <= '0; lo <= '0; pc <= '0; ir <= '0; y <= '0; mdr <= '0;
      inport <= '0; outport <= '0; z <= '0; mar <= '0; con <= 1'b0;
    end else begin
      for (int n = 0; n < 16; n++)
        if ((io.Rin && sel == 4'(n)) || io.regIn[n]) r[n] <= bus;
      if (io.HIin)      hi      <= bus;
      if (io.LOin)      lo      <= bus;
      if (io.IRin)      ir      <= bus;
      if (io.Yin)       y       <= bus;
      if (io.OUTPORTin) outport <= bus;
      if (io.MARin)     mar     <= bus[8:0];
      if (io.Zin)       z       <= alu;
      if (io.CONin)     con     <= con_next;
      if (io.MDRin)     mdr     <= io.Read ? mem[mar] : bus;
      if (io.PCin)      pc      <= io.IncPC ? pc + 32'd1 : bus;
      inport <= io.inportInput;
    end
  end

  // RAM write stores the MDR value present before this edge
  always @(posedge Clock) begin
    if (io.write) mem[mar] <= mdr;
  end

  assign io.busMuxOut  = bus;
  assign io.encoderOut = enc;
  assign io.CON        = con;
  assign io.BusMuxInR0  = io.BAout ? 32'd0 : r[0];
  assign io.BusMuxInR1  = r[1];
  assign io.BusMuxInR2  = r[2];
  assign io.BusMuxInR3  = r[3];
  assign io.BusMuxInR4  = r[4];
  assign io.BusMuxInR5  = r[5];
  assign io.BusMuxInR6  = r[6];
  assign io.BusMuxInR7  = r[7];
  assign io.BusMuxInR8  = r[8];
  assign io.BusMuxInR9  = r[9];
  assign io.BusMuxInR10 = r[10];
  assign io.BusMuxInR11 = r[11];
  assign io.BusMuxInR12 = r[12];
  assign io.BusMuxInR13 = r[13];
  assign io.BusMuxInR14 = r[14];
  assign io.BusMuxInR15 = r[15];
  assign io.BusMuxInHI      = hi;
  assign io.BusMuxInLO      = lo;
  assign io.BusMuxInZhi     = z[63:32];
  assign io.BusMuxInZlo     = z[31:0];
  assign io.BusMuxInPC      = pc;
  assign io.BusMuxInMDR     = mdr;
  assign io.BusMuxInInport  = inport;
  assign io.BusMuxInOutport = outport;
  assign io.BusMuxInY       = y;
  assign io.IRregister      = ir;
  assign io.Cregister       = c_sx;
  assign io.marToRam        = mar;
endmodule

// File: tb/tb_datapath.sv
// Bench for the single-bus datapath: directed walk through the instruction
// fetch/store sequence plus randomized strobe mixes, with every cycle's
// expected bus and register picture produced by a behavioural model.
module tb_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  datapath_if dif ();

  datapath #(.INIT_FILE(""), .RAM_DEPTH(512)) dut (.Clock(clk), .Reset(rst), .io(dif));

  // Clock/reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;
    logic hi_in, lo_in, pc_in, mdr_in, z_in, y_in, mar_in, ir_in, con_in, outp_in;
    logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, in_out, outp_out, c_out, y_out;
    logic gra, grb, grc, rin, rout, baout, rd, incpc, wr;
    logic [15:0] reg_in;
    logic [31:0] inp;
  } ctl_t;

  typedef struct packed {
    logic [31:0] bus;
    logic [4:0]  enc;
    logic        con;
    logic [15:0][31:0] r;
    logic [31:0] hi, lo, zhi, zlo, pc, mdr, inp, outp, y, ir, c;
    logic [8:0]  mar;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_ir, m_y, m_mdr, m_inp, m_outp;
  logic [63:0] m_z;
  logic [8:0]  m_mar;
  logic        m_con;
  logic [31:0] m_mem [512];

  logic [15:0][31:0] act_r;
  assign act_r = {dif.BusMuxInR15, dif.BusMuxInR14, dif.BusMuxInR13, dif.BusMuxInR12,
                  dif.BusMuxInR11, dif.BusMuxInR10, dif.BusMuxInR9, dif.BusMuxInR8,
                  dif.BusMuxInR7, dif.BusMuxInR6, dif.BusMuxInR5, dif.BusMuxInR4,
                  dif.BusMuxInR3, dif.BusMuxInR2, dif.BusMuxInR1, dif.BusMuxInR0};

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned n;
    logic [63:0] dbl;
    longint      p;
    int          sa, sb;
    n   = b[4:0];
    dbl = {a, a};
    sa  = a;
    sb  = b;
    case (op)
      5'd4:        return {32'd0, a - b};
      5'd5, 5'd13: return {32'd0, a & b};
      5'd6, 5'd14: return {32'd0, a | b};
      5'd7:        begin dbl = dbl >> n; return {32'd0, dbl[31:0]}; end
      5'd8:        begin dbl = dbl << n; return {32'd0, dbl[63:32]}; end
      5'd9:        return {32'd0, a >> n};
      5'd10:       return {32'd0, 32'(sa >>> n)};
      5'd11:       return {32'd0, a << n};
      5'd15:       return (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      5'd16:       begin p = longint'(sa) * longint'(sb); return p; end
      5'd17:       return {32'd0, 32'd0 - b};
      5'd18:       return {32'd0, ~b};
      default:     return {32'd0, a + b};
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 16; n++) m_r[n] = '0;
    m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0; m_y = '0; m_mdr = '0;
    m_inp = '0; m_outp = '0; m_z = '0; m_mar = '0; m_con = 1'b0;
  endtask

  // Expected picture for this cycle, then advance the model by one edge
  task automatic model_step(input ctl_t c, output exp_t e);
    logic [3:0]  s;
    logic [31:0] src [26];
    logic        en [26];
    logic [31:0] bus, nx_mdr;
    logic [4:0]  enc;
    logic [63:0] res;
    logic        cv;
    s = ({4{c.gra}} & m_ir[26:23]) | ({4{c.grb}} & m_ir[22:19]) | ({4{c.grc}} & m_ir[18:15]);
    for (int n = 0; n < 16; n++) begin
      en[n]  = (c.rout || c.baout) && (s == 4'(n));
      src[n] = (c.baout && n == 0) ? 32'd0 : m_r[n];
    end
    en[16] = c.hi_out;   src[16] = m_hi;
    en[17] = c.lo_out;   src[17] = m_lo;
    en[18] = c.zhi_out;  src[18] = m_z[63:32];
    en[19] = c.zlo_out;  src[19] = m_z[31:0];
    en[20] = c.pc_out;   src[20] = m_pc;
    en[21] = c.mdr_out;  src[21] = m_mdr;
    en[22] = c.in_out;   src[22] = m_inp;
    en[23] = c.c_out;    src[23] = {{13{m_ir[18]}}, m_ir[18:0]};
    en[24] = c.y_out;    src[24] = m_y;
    en[25] = c.outp_out; src[25] = m_outp;
    bus = '0;
    enc = 5'd31;
    for (int k = 25; k >= 0; k--) if (en[k]) begin bus = src[k]; enc = 5'(k); end

    e.bus = bus; e.enc = enc; e.con = m_con;
    for (int n = 0; n < 16; n++) e.r[n] = m_r[n];
    if (c.baout) e.r[0] = '0;
    e.hi = m_hi; e.lo = m_lo; e.zhi = m_z[63:32]; e.zlo = m_z[31:0]; e.pc = m_pc;
    e.mdr = m_mdr; e.inp = m_inp; e.outp = m_outp; e.y = m_y; e.ir = m_ir;
    e.c = {{13{m_ir[18]}}, m_ir[18:0]}; e.mar = m_mar;

    res = ref_alu(m_ir[31:27], m_y, bus);
    case (m_ir[20:19])
      2'b00:   cv = (bus == 0);
      2'b01:   cv = (bus != 0);
      2'b10:   cv = !bus[31];
      default: cv = bus[31];
    endcase
    nx_mdr = c.rd ? m_mem[m_mar] : bus;
    if (c.wr) m_mem[m_mar] = m_mdr;
    if (c.rst) model_reset();
    else begin
      for (int n = 0; n < 16; n++) if ((c.rin && s == 4'(n)) || c.reg_in[n]) m_r[n] = bus;
      if (c.hi_in)   m_hi = bus;
      if (c.lo_in)   m_lo = bus;
      if (c.ir_in)   m_ir = bus;
      if (c.y_in)    m_y = bus;
      if (c.outp_in) m_outp = bus;
      if (c.mar_in)  m_mar = bus[8:0];
      if (c.z_in)    m_z = res;
      if (c.con_in)  m_con = cv;
      if (c.mdr_in)  m_mdr = nx_mdr;
      if (c.pc_in)   m_pc = c.incpc ? m_pc + 1 : bus;
      m_inp = c.inp;
    end
  endtask

  // Driver tasks
  task automatic drive(input ctl_t c);
    rst = c.rst;
    dif.HIin = c.hi_in; dif.LOin = c.lo_in; dif.PCin = c.pc_in; dif.MDRin = c.mdr_in;
    dif.Zin = c.z_in; dif.Yin = c.y_in; dif.MARin = c.mar_in; dif.IRin = c.ir_in;
    dif.CONin = c.con_in; dif.OUTPORTin = c.outp_in;
    dif.HIout = c.hi_out; dif.LOout = c.lo_out; dif.ZHIout = c.zhi_out; dif.ZLOout = c.zlo_out;
    dif.PCout = c.pc_out; dif.MDRout = c.mdr_out; dif.INPORTout = c.in_out;
    dif.OUTPORTout = c.outp_out; dif.Cout = c.c_out; dif.Yout = c.y_out;
    dif.Gra = c.gra; dif.Grb = c.grb; dif.Grc = c.grc; dif.Rin = c.rin; dif.Rout = c.rout;
    dif.BAout = c.baout; dif.Read = c.rd; dif.IncPC = c.incpc; dif.write = c.wr;
    dif.regIn = c.reg_in; dif.inportInput = c.inp;
  endtask

  task automatic go(input ctl_t c);
    exp_t e;
    @(posedge clk);
    #1;
    drive(c);
    model_step(c, e);
    exp_q.push_back(e);
  endtask

  function automatic ctl_t blank(input logic [31:0] v);
    ctl_t c = '0;
    c.inp = v;
    return c;
  endfunction

  // Present a value on the inport for a cycle, then move it into register n
  task automatic load_reg(input int n, input logic [31:0] v);
    ctl_t c;
    go(blank(v));
    c = blank(v); c.in_out = 1'b1; c.reg_in = 16'(1 << n);
    go(c);
  endtask

  task automatic load_ir(input logic [31:0] v);
    ctl_t c;
    go(blank(v));
    c = blank(v); c.in_out = 1'b1; c.ir_in = 1'b1;
    go(c);
  endtask

  function automatic logic p(input int k);
    return $urandom_range(0, k - 1) == 0;
  endfunction

  function automatic ctl_t rand_ctl();
    ctl_t c = '0;
    c.rst = p(80);
    c.hi_in = p(4); c.lo_in = p(4); c.pc_in = p(4); c.mdr_in = p(4); c.z_in = p(3);
    c.y_in = p(3); c.mar_in = p(4); c.ir_in = p(6); c.con_in = p(3); c.outp_in = p(4);
    c.hi_out = p(10); c.lo_out = p(10); c.zhi_out = p(8); c.zlo_out = p(8); c.pc_out = p(10);
    c.mdr_out = p(10); c.in_out = p(4); c.outp_out = p(10); c.c_out = p(8); c.y_out = p(10);
    c.gra = p(2); c.grb = p(2); c.grc = p(2); c.rin = p(4); c.rout = p(6); c.baout = p(10);
    c.incpc = p(2); c.wr = p(5);
    c.reg_in = p(3) ? 16'(1 << $urandom_range(0, 15)) : 16'd0;
    c.inp = p(4) ? 32'(1 << $urandom_range(0, 31)) : $urandom;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard monitor: one expected picture per driven cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bus", dif.busMuxOut, e.bus);
        chk("encoder", dif.encoderOut, e.enc);
        chk("con", dif.CON, e.con);
        for (int n = 0; n < 16; n++) chk($sformatf("r%0d", n), act_r[n], e.r[n]);
        chk("hi", dif.BusMuxInHI, e.hi);
        chk("lo", dif.BusMuxInLO, e.lo);
        chk("zhi", dif.BusMuxInZhi, e.zhi);
        chk("zlo", dif.BusMuxInZlo, e.zlo);
        chk("pc", dif.BusMuxInPC, e.pc);
        chk("mdr", dif.BusMuxInMDR, e.mdr);
        chk("inport", dif.BusMuxInInport, e.inp);
        chk("outport", dif.BusMuxInOutport, e.outp);
        chk("y", dif.BusMuxInY, e.y);
        chk("ir", dif.IRregister, e.ir);
        chk("cregister", dif.Cregister, e.c);
        chk("mar", dif.marToRam, e.mar);
      end
    end
  end

  // Stimulus
  initial begin
    ctl_t c;
    drive('0);
    rst = 1'b1;
    for (int n = 0; n < 512; n++) m_mem[n] = '0;
    model_reset();
    repeat (2) @(posedge clk);

    go(blank(0));
    // Inport to PC, inport to R4
    go(blank(4));
    c = blank(4); c.in_out = 1; c.pc_in = 1; go(c);
    load_reg(4, 27);
    // Place "st R4,0x90" at RAM[4]
    go(blank(32'h1200_0090));
    c = blank(32'h1200_0090); c.in_out = 1; c.mdr_in = 1; go(c);
    c = blank(0); c.pc_out = 1; c.mar_in = 1; go(c);
    c = blank(0); c.wr = 1; go(c);
    // Fetch and execute the store
    c = blank(0); c.pc_out = 1; c.mar_in = 1; go(c);
    c = blank(0); c.rd = 1; c.mdr_in = 1; c.pc_in = 1; c.incpc = 1; go(c);
    c = blank(0); c.mdr_out = 1; c.ir_in = 1; go(c);
    c = blank(0); c.grb = 1; c.baout = 1; c.y_in = 1; go(c);
    c = blank(0); c.c_out = 1; c.z_in = 1; go(c);
    c = blank(0); c.zlo_out = 1; c.mar_in = 1; go(c);
    c = blank(0); c.gra = 1; c.rout = 1; c.mdr_in = 1; c.wr = 1; go(c);
    c = blank(0); c.wr = 1; go(c);
    // Read back RAM[0x90] after overwriting MDR
    c = blank(0); c.pc_out = 1; c.mdr_in = 1; go(c);
    c = blank(0); c.rd = 1; c.mdr_in = 1; go(c);
    // add R1,R2,R3 then mul with the same register fields
    load_reg(2, 5);
    load_reg(3, 32'hFFFF_FFF9);
    load_ir({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0});
    c = blank(0); c.grb = 1; c.rout = 1; c.y_in = 1; go(c);
    c = blank(0); c.grc = 1; c.rout = 1; c.z_in = 1; go(c);
    load_reg(2, 32'h0001_0000);
    load_reg(3, 32'h0001_0000);
    load_ir({5'b10000, 4'd1, 4'd2, 4'd3, 15'd0});
    c = blank(0); c.grb = 1; c.rout = 1; c.y_in = 1; go(c);
    c = blank(0); c.grc = 1; c.rout = 1; c.z_in = 1; go(c);
    c = blank(0); c.zhi_out = 1; c.hi_in = 1; go(c);
    // Branch flag under two c2 codes
    load_ir(32'h0000_0000);
    c = blank(5); c.in_out = 1; c.con_in = 1; go(c);
    c = blank(5); c.in_out = 1; c.con_in = 1; go(c);
    load_ir(32'h0018_0000);
    go(blank(32'h8000_0000));
    c = blank(32'h8000_0000); c.in_out = 1; c.con_in = 1; go(c);
    // Competing sources, then a mid-run reset
    c = blank(0); c.pc_out = 1; c.mdr_out = 1; c.outp_in = 1; go(c);
    c = blank(0); c.rst = 1; go(c);
    go(blank(0));

    for (int i = 0; i < 600; i++) go(rand_ctl());
    go(blank(0));
    go(blank(0));
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
